alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 102 ++++++++++
 tb/tb_alu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered N-bit ALU: eight operations, one-cycle latency, async active-high reset.
// Defining ALU_OVF_EN adds a registered signed-overflow output ovf.
module alu #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   OPCODE,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cOut
`ifdef ALU_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N:0]    sum_s;
    logic [N:0]    diff_s;
    logic [SW-1:0] shamt_s;
    logic          slt_s;
    logic [N-1:0]  s_d;
    logic          c_d;
    logic [N-1:0]  s_q;
    logic          c_q;

    assign sum_s   = {1'b0, a} + {1'b0, b};
    // Extra MSB of the widened difference is the borrow; cOut reports its inverse.
    assign diff_s  = {1'b0, a} - {1'b0, b};
    assign shamt_s = b[SW-1:0];
    assign slt_s   = ($signed(a) < $signed(b));

    // Next-state result and carry selection.
    always_comb begin
        s_d = '0;
        c_d = 1'b0;
        case (OPCODE)
            3'b000: begin
                s_d = sum_s[N-1:0];
                c_d = sum_s[N];
            end
            3'b001: begin
                s_d = diff_s[N-1:0];
                c_d = ~diff_s[N];
            end
            3'b010: s_d = a & b;
            3'b011: s_d = a | b;
            3'b100: s_d = ~(a | b);
            3'b101: s_d = {{(N-1){1'b0}}, slt_s};
            3'b110: s_d = a << shamt_s;
            3'b111: s_d = a >> shamt_s;
            default: begin
                s_d = '0;
                c_d = 1'b0;
            end
        endcase
    end

    // Result and carry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
            c_q <= 1'b0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign s    = s_q;
    assign cOut = c_q;

`ifdef ALU_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow: operands of compatible sign producing a result of the other sign.
    always_comb begin
        ovf_d = 1'b0;
        case (OPCODE)
            3'b000:  ovf_d = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
            3'b001:  ovf_d = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
            default: ovf_d = 1'b0;
        endcase
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: sweep, directed corner cases, random traffic, reset behaviour.
module tb_alu;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic [2:0]   OPCODE;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         cOut;
`ifdef ALU_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] s;
        logic         c;
        logic         o;
        logic [2:0]   op;
        logic [N-1:0] x;
        logic [N-1:0] y;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] last_s;

    alu #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .OPCODE (OPCODE),
        .a      (a),
        .b      (b),
        .s      (s),
`ifdef ALU_OVF_EN
        .ovf    (ovf),
`endif
        .cOut   (cOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t   e;
        longint m, ua, ub, sa, sb, r, sr;
        int     sh;
        m  = longint'(1) << N;
        ua = longint'(x);
        ub = longint'(y);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sh = int'(ub % N);
        r  = 0;
        e.c = 1'b0;
        e.o = 1'b0;
        case (op)
            3'd0: begin
                r   = ua + ub;
                e.c = (r >= m);
                r   = r % m;
                sr  = sa + sb;
                e.o = (sr >= m / 2) || (sr < -(m / 2));
            end
            3'd1: begin
                r   = ua - ub;
                e.c = (ua >= ub);
                if (r < 0) r = r + m;
                sr  = sa - sb;
                e.o = (sr >= m / 2) || (sr < -(m / 2));
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = (m - 1) - (ua | ub);
            3'd5: r = (sa < sb) ? 1 : 0;
            3'd6: r = (ua * (longint'(1) << sh)) % m;
            3'd7: r = ua / (longint'(1) << sh);
            default: r = 0;
        endcase
        e.s  = r[N-1:0];
        e.op = op;
        e.x  = x;
        e.y  = y;
        return e;
    endfunction

    // Monitor: one result per clock; compare against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                last_s = e.s;
                total++;
                if (s !== e.s || cOut !== e.c) begin
                    bad++;
                    $display("FAIL result op=%0d a=%h b=%h: got s=%h cOut=%b, expected s=%h cOut=%b",
                             e.op, e.x, e.y, s, cOut, e.s, e.c);
                end
`ifdef ALU_OVF_EN
                total++;
                if (ovf !== e.o) begin
                    bad++;
                    $display("FAIL ovf op=%0d a=%h b=%h: got %b, expected %b", e.op, e.x, e.y, ovf, e.o);
                end
`endif
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        OPCODE = op;
        a      = x;
        b      = y;
        if (!rst) q.push_back(model(op, x, y));
        #1;
        if (!rst) begin
            total++;
            if (s !== last_s) begin
                bad++;
                $display("FAIL hold: s changed with inputs to %h, expected %h", s, last_s);
            end
        end
    endtask

    initial begin
        logic [N-1:0] x, y;
        rst    = 1'b1;
        OPCODE = 3'd0;
        a      = '0;
        b      = '0;
        last_s = '0;
        #3;
        total++;
        if (s !== '0 || cOut !== 1'b0) begin
            bad++;
            $display("FAIL reset: got s=%h cOut=%b, expected 0/0", s, cOut);
        end
        @(posedge clk);
        #3 rst = 1'b0;

        for (int op = 0; op < 8; op++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    issue(op[2:0], N'(i), N'(j));

        issue(3'd0, 16'hFFFF, 16'h0001);
        issue(3'd1, 16'h0000, 16'h0001);
        issue(3'd0, 16'h7FFF, 16'h0001);
        issue(3'd1, 16'h8000, 16'h0001);
        issue(3'd1, 16'h0003, 16'h0005);
        issue(3'd5, 16'h0003, 16'h0005);
        issue(3'd5, 16'h8000, 16'h0001);
        issue(3'd5, 16'h0001, 16'h8000);
        issue(3'd6, 16'h0001, 16'h0013);
        issue(3'd7, 16'h8000, 16'h000F);
        issue(3'd6, 16'hA5A5, 16'hFFF0);
        issue(3'd7, 16'hA5A5, 16'h0000);
        issue(3'd1, 16'h1234, 16'h1234);

        for (int k = 0; k < 1500; k++) begin
            x = N'($urandom);
            y = N'($urandom);
            if ($urandom_range(0, 7) == 0) x = (k % 2 == 0) ? 16'hFFFF : 16'h8000;
            if ($urandom_range(0, 7) == 0) y = (k % 3 == 0) ? 16'h7FFF : 16'h0001;
            issue(3'($urandom_range(0, 7)), x, y);
        end

        issue(3'd0, 16'h0005, 16'h0006);
        @(negedge clk);
        OPCODE = 3'd0;
        a      = 16'h0007;
        b      = 16'h0007;
        #2;
        rst = 1'b1;
        q.delete();
        last_s = '0;
        #1;
        total++;
        if (s !== '0 || cOut !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got s=%h cOut=%b, expected 0/0", s, cOut);
        end
        @(posedge clk);
        #1;
        OPCODE = 3'd3;
        a      = 16'hFFFF;
        b      = 16'h00FF;
        @(posedge clk);
        #1;
        total++;
        if (s !== '0 || cOut !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold: got s=%h cOut=%b, expected 0/0", s, cOut);
        end
        #2 rst = 1'b0;
        issue(3'd0, 16'hFFFF, 16'h0003);
        issue(3'd4, 16'h0F0F, 16'h00F0);

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
